// File: rtl/alu_cmd_sequencer_if.sv
// Command/response bundle between the control path and alu_cmd_sequencer.
// master: control path (issues commands, consumes responses)
// slave : the sequencer
interface alu_cmd_sequencer_if #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [REG_AW-1:0] cmd_dst;
    logic [REG_AW-1:0] cmd_src_a;
    logic [REG_AW-1:0] cmd_src_b;
    logic              cmd_imm_en;
    logic [WIDTH-1:0]  cmd_imm;
    logic [3:0]        cmd_rep;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data;
    logic [REG_AW-1:0] rsp_dst;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b,
               cmd_imm_en, cmd_imm, cmd_rep, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_dst
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b,
               cmd_imm_en, cmd_imm, cmd_rep, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_dst
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: drives an external combinational 32-bit ALU from a
// command stream. Operands come from a small register file or an immediate,
// an op can be applied repeatedly (accumulate), the result is written back
// and returned on the response channel.
// Optional build macro FLAGS_EN adds rsp_zero / rsp_neg result flags.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// EXEC  | ALU operands presented; sample alu_y each edge, cnt iterations left
// RESP  | result held on the response channel until rsp_ready
module alu_cmd_sequencer #(
    parameter int WIDTH  = 32,
    parameter int NREG   = 4,
    parameter int REG_AW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_cmd_sequencer_if.slave bus,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_sel,
    input  logic [WIDTH-1:0]   alu_y,
    output logic               busy
`ifdef FLAGS_EN
    ,
    output logic               rsp_zero,
    output logic               rsp_neg
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  regs [NREG];
    logic [3:0]        cnt;
    logic [REG_AW-1:0] dst;
    logic              cmd_fire;
    logic              rsp_fire;
    logic              last_iter;

    assign cmd_fire  = (state == IDLE) && bus.cmd_valid;
    assign rsp_fire  = (state == RESP) && bus.rsp_ready;
    assign last_iter = (cnt == 4'd0);

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a response handshake returns to IDLE, so a new command
    // can never be accepted in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire)  state_nxt = EXEC;
            EXEC:    if (last_iter) state_nxt = RESP;
            RESP:    if (rsp_fire)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                busy          = 1'b0;
            end
            RESP:    bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture at accept, accumulate/writeback in EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sel      <= '0;
            cnt          <= '0;
            dst          <= '0;
            bus.rsp_data <= '0;
            bus.rsp_dst  <= '0;
`ifdef FLAGS_EN
            rsp_zero     <= 1'b0;
            rsp_neg      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        alu_a   <= regs[bus.cmd_src_a];
                        alu_b   <= bus.cmd_imm_en ? bus.cmd_imm : regs[bus.cmd_src_b];
                        alu_sel <= bus.cmd_op;
                        cnt     <= bus.cmd_rep;
                        dst     <= bus.cmd_dst;
                    end
                end
                EXEC: begin
                    if (!last_iter) begin
                        alu_a <= alu_y;
                        cnt   <= cnt - 4'd1;
                    end else begin
                        regs[dst]    <= alu_y;
                        bus.rsp_data <= alu_y;
                        bus.rsp_dst  <= dst;
`ifdef FLAGS_EN
                        rsp_zero     <= (alu_y == '0);
                        rsp_neg      <= alu_y[WIDTH-1];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: models the external ALU and
// keeps an abstract register-file model of the expected results.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_sel;
    logic        busy;
`ifdef FLAGS_EN
    logic        rsp_zero, rsp_neg;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mregs [4];

    alu_cmd_sequencer_if #(.WIDTH(32), .REG_AW(2)) bus ();

    alu_cmd_sequencer #(.WIDTH(32), .NREG(4), .REG_AW(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_sel (alu_sel),
        .alu_y   (alu_y),
        .busy    (busy)
`ifdef FLAGS_EN
        ,
        .rsp_zero(rsp_zero),
        .rsp_neg (rsp_neg)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0: return a;
            3'd1: return a - b;
            3'd2: return a + b;
            3'd3: return a + b + 32'd1;
            3'd4: return a + ~b;
            3'd5: return a + ~b + 32'd1;
            3'd6: return a - 32'd1;
            default: return b;
        endcase
    endfunction

    // External combinational ALU.
    always_comb alu_y = alu_f(alu_a, alu_b, alu_sel);

    task automatic model_cmd(input logic [2:0] op, input logic [1:0] d, input logic [1:0] sa,
                             input logic [1:0] sb, input logic ie, input logic [31:0] imm,
                             input int rep, output logic [31:0] res);
        logic [31:0] acc, b;
        acc = mregs[sa];
        b   = ie ? imm : mregs[sb];
        for (int i = 0; i <= rep; i++) acc = alu_f(acc, b, op);
        mregs[d] = acc;
        res = acc;
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [1:0] d, input logic [1:0] sa,
                           input logic [1:0] sb, input logic ie, input logic [31:0] imm,
                           input logic [3:0] rep);
        bus.cmd_op = op; bus.cmd_dst = d; bus.cmd_src_a = sa; bus.cmd_src_b = sb;
        bus.cmd_imm_en = ie; bus.cmd_imm = imm; bus.cmd_rep = rep;
    endtask

    // Offers a command from IDLE and waits for the response; lat counts edges
    // from offering the command (accept edge included) to rsp_valid.
    task automatic run_cmd(input logic [2:0] op, input logic [1:0] d, input logic [1:0] sa,
                           input logic [1:0] sb, input logic ie, input logic [31:0] imm,
                           input logic [3:0] rep, output int lat, output bit to);
        set_cmd(op, d, sa, sb, ie, imm, rep);
        bus.cmd_valid = 1'b1;
        lat = 0;
        while (!bus.cmd_ready && lat < 40) begin @(posedge clk); #1; lat++; end
        @(posedge clk); #1; lat++;
        bus.cmd_valid = 1'b0;
        while (!bus.rsp_valid && lat < 80) begin @(posedge clk); #1; lat++; end
        to = !bus.rsp_valid;
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        n_cmp++; if (alu_sel !== 3'd0) begin n_err++; $display("FAIL reset_alu_sel: got %0d expected 0", alu_sel); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (bus.rsp_data !== 32'd0) begin n_err++; $display("FAIL reset_rsp_data: got %0h expected 0", bus.rsp_data); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mregs[i] = 32'd0;
        @(posedge clk); #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    endtask

    task automatic test_imm_add();
        int lat; bit to; logic [31:0] r;
        model_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b1, 32'd5, 0, r);
        run_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b1, 32'd5, 4'd0, lat, to);
        n_cmp++; if (to || bus.rsp_data !== 32'd5) begin n_err++; $display("FAIL imm_load: got %0h timeout %0d expected 5", bus.rsp_data, to); end
        take_rsp();
        model_cmd(3'd2, 2'd2, 2'd1, 2'd0, 1'b1, 32'd7, 0, r);
        run_cmd(3'd2, 2'd2, 2'd1, 2'd0, 1'b1, 32'd7, 4'd0, lat, to);
        n_cmp++; if (to || bus.rsp_data !== 32'd12) begin n_err++; $display("FAIL imm_add_data: got %0h timeout %0d expected c", bus.rsp_data, to); end
        n_cmp++; if (bus.rsp_dst !== 2'd2) begin n_err++; $display("FAIL imm_add_dst: got %0d expected 2", bus.rsp_dst); end
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL imm_add_latency: got %0d expected 2", lat); end
        take_rsp();
    endtask

    task automatic test_repeat();
        int lat; bit to; logic [31:0] r;
        model_cmd(3'd2, 2'd1, 2'd1, 2'd0, 1'b1, 32'd3, 3, r);
        run_cmd(3'd2, 2'd1, 2'd1, 2'd0, 1'b1, 32'd3, 4'd3, lat, to);
        n_cmp++; if (to || bus.rsp_data !== 32'd17) begin n_err++; $display("FAIL repeat_data: got %0d timeout %0d expected 17", bus.rsp_data, to); end
        n_cmp++; if (lat != 5) begin n_err++; $display("FAIL repeat_latency: got %0d expected 5", lat); end
        take_rsp();
        model_cmd(3'd0, 2'd1, 2'd1, 2'd0, 1'b0, 32'd0, 0, r);
        run_cmd(3'd0, 2'd1, 2'd1, 2'd0, 1'b0, 32'd0, 4'd0, lat, to);
        n_cmp++; if (to || bus.rsp_data !== 32'd17) begin n_err++; $display("FAIL repeat_readback: got %0d timeout %0d expected 17", bus.rsp_data, to); end
        take_rsp();
    endtask

    task automatic test_wrap();
        int lat; bit to; logic [31:0] r;
        model_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b1, 32'd0, 0, r);
        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b1, 32'd0, 4'd0, lat, to);
`ifdef FLAGS_EN
        n_cmp++; if (rsp_zero !== 1'b1) begin n_err++; $display("FAIL zero_flag: got %b expected 1", rsp_zero); end
`endif
        take_rsp();
        model_cmd(3'd6, 2'd0, 2'd0, 2'd0, 1'b0, 32'd0, 0, r);
        run_cmd(3'd6, 2'd0, 2'd0, 2'd0, 1'b0, 32'd0, 4'd0, lat, to);
        n_cmp++; if (to || bus.rsp_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_data: got %0h timeout %0d expected ffffffff", bus.rsp_data, to); end
`ifdef FLAGS_EN
        n_cmp++; if (rsp_neg !== 1'b1 || rsp_zero !== 1'b0) begin n_err++; $display("FAIL wrap_flags: got neg %b zero %b expected neg 1 zero 0", rsp_neg, rsp_zero); end
`endif
        take_rsp();
    endtask

    task automatic test_backpressure();
        int lat; bit to; logic [31:0] r;
        model_cmd(3'd2, 2'd3, 2'd1, 2'd2, 1'b0, 32'd0, 0, r);
        run_cmd(3'd2, 2'd3, 2'd1, 2'd2, 1'b0, 32'd0, 4'd0, lat, to);
        n_cmp++; if (to || bus.rsp_data !== 32'd29) begin n_err++; $display("FAIL bp_data: got %0d timeout %0d expected 29", bus.rsp_data, to); end
        set_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b1, 32'hDEAD_BEEF, 4'd0);
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd29 || bus.rsp_dst !== 2'd3)
                begin n_err++; $display("FAIL bp_hold: got valid %b data %0d dst %0d expected 1 29 3", bus.rsp_valid, bus.rsp_data, bus.rsp_dst); end
            n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_cmd_ready: got %b expected 0", bus.cmd_ready); end
        end
        bus.cmd_valid = 1'b0;
        take_rsp();
        n_cmp++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
            begin n_err++; $display("FAIL bp_release: got busy %b valid %b ready %b expected 0 0 1", busy, bus.rsp_valid, bus.cmd_ready); end
        model_cmd(3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 32'd0, 0, r);
        run_cmd(3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 32'd0, 4'd0, lat, to);
        n_cmp++; if (to || bus.rsp_data !== r) begin n_err++; $display("FAIL bp_ignored_cmd: got %0h timeout %0d expected %0h", bus.rsp_data, to, r); end
        take_rsp();
    endtask

    task automatic test_reset_in_exec();
        int lat; bit to; bit seen; logic [31:0] r;
        set_cmd(3'd2, 2'd2, 2'd2, 2'd0, 1'b1, 32'd1, 4'd5);
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rexec_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_sel !== 3'd0)
            begin n_err++; $display("FAIL rexec_alu_regs: got a %0h b %0h sel %0d expected 0 0 0", alu_a, alu_b, alu_sel); end
        n_cmp++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.rsp_dst !== 2'd0)
            begin n_err++; $display("FAIL rexec_state: got valid %b busy %b dst %0d expected 0 0 0", bus.rsp_valid, busy, bus.rsp_dst); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mregs[i] = 32'd0;
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (bus.rsp_valid) seen = 1'b1; end
        n_cmp++; if (seen) begin n_err++; $display("FAIL rexec_no_rsp: got response after reset expected none"); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rexec_cmd_ready: got %b expected 1", bus.cmd_ready); end
        for (int k = 0; k < 4; k++) begin
            model_cmd(3'd0, 2'(k), 2'(k), 2'd0, 1'b0, 32'd0, 0, r);
            run_cmd(3'd0, 2'(k), 2'(k), 2'd0, 1'b0, 32'd0, 4'd0, lat, to);
            n_cmp++; if (to || bus.rsp_data !== 32'd0) begin n_err++; $display("FAIL rexec_reg_cleared: reg %0d got %0h timeout %0d expected 0", k, bus.rsp_data, to); end
            take_rsp();
        end
    endtask

    task automatic test_random();
        int lat; bit to; int d; logic [31:0] r;
        logic [2:0] op; logic [1:0] dd, sa, sb; logic ie; logic [31:0] imm; logic [3:0] rep;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(7)); dd = 2'($urandom_range(3)); sa = 2'($urandom_range(3));
            sb = 2'($urandom_range(3)); ie = 1'($urandom_range(1)); rep = 4'($urandom_range(15));
            imm = (n % 5 == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(3)) : $urandom;
            model_cmd(op, dd, sa, sb, ie, imm, int'(rep), r);
            run_cmd(op, dd, sa, sb, ie, imm, rep, lat, to);
            n_cmp++; if (to || bus.rsp_data !== r || bus.rsp_dst !== dd)
                begin n_err++; $display("FAIL rand_rsp[%0d]: got %0h dst %0d timeout %0d expected %0h dst %0d", n, bus.rsp_data, bus.rsp_dst, to, r, dd); end
            n_cmp++; if (lat != int'(rep) + 2) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, int'(rep) + 2); end
`ifdef FLAGS_EN
            n_cmp++; if (rsp_zero !== (r == 32'd0) || rsp_neg !== r[31])
                begin n_err++; $display("FAIL rand_flags[%0d]: got z %b n %b expected z %b n %b", n, rsp_zero, rsp_neg, (r == 32'd0), r[31]); end
`endif
            d = $urandom_range(3);
            repeat (d) begin
                @(posedge clk); #1;
                n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== r)
                    begin n_err++; $display("FAIL rand_hold[%0d]: got valid %b data %0h expected 1 %0h", n, bus.rsp_valid, bus.rsp_data, r); end
            end
            take_rsp();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] r, e;
        logic [2:0] op; logic [1:0] dd, sa; logic [31:0] imm; logic [3:0] rep;
        int cyc; int prev_rep; int wait_cyc;
        prev_rep = 0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            op = 3'($urandom_range(7)); dd = 2'($urandom_range(3)); sa = 2'($urandom_range(3));
            imm = $urandom; rep = 4'($urandom_range(4));
            model_cmd(op, dd, sa, 2'd0, 1'b1, imm, int'(rep), r);
            exp_q.push_back(r);
            set_cmd(op, dd, sa, 2'd0, 1'b1, imm, rep);
            bus.cmd_valid = 1'b1;
            cyc = 0;
            while (!bus.cmd_ready && cyc < 40) begin
                @(posedge clk); #1; cyc++;
                if (bus.rsp_valid) begin
                    e = exp_q.pop_front();
                    n_cmp++; if (bus.rsp_data !== e) begin n_err++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", k - 1, bus.rsp_data, e); end
                end
            end
            @(posedge clk); #1; cyc++;
            if (k > 0) begin
                n_cmp++; if (cyc != prev_rep + 3) begin n_err++; $display("FAIL b2b_interval[%0d]: got %0d expected %0d", k, cyc, prev_rep + 3); end
            end
            prev_rep = int'(rep);
        end
        bus.cmd_valid = 1'b0;
        wait_cyc = 0;
        while (!bus.rsp_valid && wait_cyc < 40) begin @(posedge clk); #1; wait_cyc++; end
        n_cmp++; if (!bus.rsp_valid || exp_q.size() != 1) begin n_err++; $display("FAIL b2b_last: got valid %b pending %0d expected 1 1", bus.rsp_valid, exp_q.size()); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if (bus.rsp_data !== e) begin n_err++; $display("FAIL b2b_last_data: got %0h expected %0h", bus.rsp_data, e); end
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle: got %b expected 1", bus.cmd_ready); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        set_cmd(3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 32'd0, 4'd0);
        for (int i = 0; i < 4; i++) mregs[i] = 32'd0;
        test_reset();
        test_imm_add();
        test_repeat();
        test_wrap();
        test_backpressure();
        test_reset_in_exec();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
